dac_spi_driver: RTL and testbench

- Downstream consumer of the square-wave generator's 8-bit `wave_out`; drives an external 8-bit SPI DAC (MCP4901-style 16-bit frame).
- Latches a sample, serialises the frame MSB-first in SPI mode 0, then pulses LDAC so the analog output updates.
- Holds one pending sample with latest-wins overwrite, so a fast-changing source never stalls the transfer.

---
 rtl/dac_spi_driver_if.sv | 26 ++
 rtl/dac_spi_driver.sv | 110 +++++++++++
 tb/tb_dac_spi_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_driver_if.sv
// dac_spi_driver_if: sample request channel plus SPI DAC pins and status of dac_spi_driver
//   sample_in/sample_valid       : upstream sample and single-cycle request
//   cs_n/sclk/mosi/ldac_n        : SPI mode-0 DAC pins
//   busy/frame_done/overrun      : frame status pulses and level
//   last_sent                    : data byte of the most recently completed frame
//   slave modport = the driver, master modport = the sample source / observer
interface dac_spi_driver_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       ldac_n;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic [7:0] last_sent;
    modport master (
        output sample_in, sample_valid,
        input  cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun, last_sent
    );
    modport slave (
        input  sample_in, sample_valid,
        output cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun, last_sent
    );
endinterface

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: serialises 8-bit samples into MCP4901-style 16-bit SPI mode-0 frames and pulses LDAC
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : dac_spi_driver_if.slave (sample_in/sample_valid in; cs_n, sclk, mosi, ldac_n,
//           busy, frame_done, overrun, last_sent out)
module dac_spi_driver #(
    parameter int         CLK_DIV       = 2,
    parameter logic [3:0] CFG           = 4'b0011,
    parameter bit         CHANGE_DETECT = 1'b1
) (
    input logic              clk,
    input logic              reset,
    dac_spi_driver_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, LATCH} state_t;
    state_t      state, state_nx;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic [7:0]  data_q, pending_data, ref_q, last_sent_q;
    logic        pending_valid;
    logic        req, div_end, start;
    logic [7:0]  load_data;
    logic        cs_n_c, sclk_c, mosi_c, ldac_n_c, busy_c, frame_done_c;

    assign req       = bus.sample_valid | (CHANGE_DETECT && bus.sample_in != ref_q);
    assign div_end   = div_cnt == 8'(CLK_DIV - 1);
    assign start     = state == IDLE && (pending_valid || req);
    // a request arriving in IDLE beats a stale pending sample
    assign load_data = req ? bus.sample_in : pending_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx     = state;
        cs_n_c       = 1'b1;
        sclk_c       = 1'b0;
        mosi_c       = 1'b0;
        ldac_n_c     = 1'b1;
        busy_c       = 1'b1;
        frame_done_c = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (start) state_nx = SETUP;
            end
            SETUP: begin
                cs_n_c = 1'b0;
                mosi_c = shreg[15];
                if (div_end) state_nx = HIGH;
            end
            HIGH: begin
                cs_n_c = 1'b0;
                sclk_c = 1'b1;
                mosi_c = shreg[15];
                if (div_end) state_nx = LOW;
            end
            LOW: begin
                cs_n_c = 1'b0;
                mosi_c = shreg[15];
                if (div_end) state_nx = bit_cnt == 4'd15 ? LATCH : HIGH;
            end
            LATCH: begin
                ldac_n_c     = 1'b0;
                frame_done_c = div_end;
                if (div_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data_q        <= '0;
            pending_data  <= '0;
            pending_valid <= 1'b0;
            ref_q         <= '0;
            last_sent_q   <= '0;
        end else begin
            div_cnt <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
            if (state == IDLE) bit_cnt <= '0;
            if (start) begin
                shreg  <= {CFG, load_data, 4'b0000};
                data_q <= load_data;
            end
            // shifting on the HIGH->LOW boundary makes mosi change right after the falling edge
            if (state == HIGH && div_end) shreg <= {shreg[14:0], 1'b0};
            if (state == LOW && div_end && bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
            if (frame_done_c) last_sent_q <= data_q;
            if (req) begin
                ref_q        <= bus.sample_in;
                pending_data <= bus.sample_in;
            end
            pending_valid <= start ? 1'b0 : (req | pending_valid);
        end

    assign bus.cs_n       = cs_n_c;
    assign bus.sclk       = sclk_c;
    assign bus.mosi       = mosi_c;
    assign bus.ldac_n     = ldac_n_c;
    assign bus.busy       = busy_c;
    assign bus.frame_done = frame_done_c;
    assign bus.overrun    = req & pending_valid;
    assign bus.last_sent  = last_sent_q;
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: three driver instances (CLK_DIV 2/2/1, CHANGE_DETECT 0/1/0) checked cycle by cycle
// against a transaction-level model, plus SPI frame decoding for the directed scenarios
module tb_dac_spi_driver;
    localparam int DIV[3]  = '{2, 2, 1};
    localparam int CDET[3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] smp[3];
    logic       vld[3];
    logic [6:0] obs[3];
    logic [7:0] lst[3];

    int checks = 0, errors = 0, n = 0;
    int         st[3];
    logic [7:0] cur[3], pd[3], rf[3], ls[3];
    logic       pv[3];
    logic [6:0] prev[3];
    logic [15:0] rx[3], rx_last[3];
    int rx_bits[3], rx_nbits[3], stray[3], done_cnt[3], ovr_cnt[3], busy_cnt[3], fd_n[3];

    always #5 clk = ~clk;

    dac_spi_driver_if b0();
    dac_spi_driver_if b1();
    dac_spi_driver_if b2();
    dac_spi_driver #(.CLK_DIV(2), .CFG(4'b0011), .CHANGE_DETECT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    dac_spi_driver #(.CLK_DIV(2), .CFG(4'b0011), .CHANGE_DETECT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    dac_spi_driver #(.CLK_DIV(1), .CFG(4'b0011), .CHANGE_DETECT(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));

    assign b0.sample_in = smp[0];
    assign b0.sample_valid = vld[0];
    assign b1.sample_in = smp[1];
    assign b1.sample_valid = vld[1];
    assign b2.sample_in = smp[2];
    assign b2.sample_valid = vld[2];
    assign obs[0] = {b0.cs_n, b0.sclk, b0.mosi, b0.ldac_n, b0.busy, b0.frame_done, b0.overrun};
    assign obs[1] = {b1.cs_n, b1.sclk, b1.mosi, b1.ldac_n, b1.busy, b1.frame_done, b1.overrun};
    assign obs[2] = {b2.cs_n, b2.sclk, b2.mosi, b2.ldac_n, b2.busy, b2.frame_done, b2.overrun};
    assign lst[0] = b0.last_sent;
    assign lst[1] = b1.last_sent;
    assign lst[2] = b2.last_sent;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, n, got, exp);
        end
    endtask

    // pin vector {cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun} from frame position arithmetic
    function automatic logic [6:0] exp_pins(int i, logic ov);
        int d = DIV[i];
        int k, p, b;
        logic [15:0] f;
        if (st[i] >= 0 && n >= st[i] && n < st[i] + 34 * d) begin
            k = n - st[i];
            p = k / d;
            b = 15 - p / 2;
            f = {4'b0011, cur[i], 4'b0000};
            return {k < 33 * d ? 1'b0 : 1'b1, (p % 2 == 1 && p <= 32),
                    (p <= 32 && b >= 0) ? f[b] : 1'b0, k >= 33 * d ? 1'b0 : 1'b1,
                    1'b1, k == 34 * d - 1, ov};
        end
        return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ov};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            st[i] = -1; cur[i] = 0; pd[i] = 0; rf[i] = 0; ls[i] = 0; pv[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic r);
        logic idle;
        idle = !(st[i] >= 0 && n < st[i] + 34 * DIV[i]);
        if (st[i] >= 0 && n == st[i] + 34 * DIV[i] - 1) ls[i] = cur[i];
        if (idle && (pv[i] || r)) begin
            cur[i] = r ? smp[i] : pd[i];
            st[i] = n + 1;
            pv[i] = 1'b0;
        end else if (r) begin
            pv[i] = 1'b1;
            pd[i] = smp[i];
        end
        if (r) rf[i] = smp[i];
    endtask

    task automatic tick();
        logic r;
        #1;
        for (int i = 0; i < 3; i++) begin
            r = vld[i] | (CDET[i] != 0 && smp[i] != rf[i]);
            check($sformatf("pins%0d", i), 32'(obs[i]), 32'(exp_pins(i, !reset && r && pv[i])));
            check($sformatf("last_sent%0d", i), 32'(lst[i]), 32'(ls[i]));
            if (prev[i][6] && !obs[i][6]) begin rx[i] = 0; rx_bits[i] = 0; end
            if (!prev[i][5] && obs[i][5]) begin
                if (obs[i][6]) stray[i]++;
                else begin rx[i] = {rx[i][14:0], obs[i][4]}; rx_bits[i]++; end
            end
            if (!prev[i][6] && obs[i][6]) begin rx_last[i] = rx[i]; rx_nbits[i] = rx_bits[i]; end
            if (obs[i][1]) begin done_cnt[i]++; fd_n[i] = n; end
            if (obs[i][0]) ovr_cnt[i]++;
            if (obs[i][2]) busy_cnt[i]++;
            prev[i] = obs[i];
            if (!reset) model_step(i, r);
        end
        n++;
        @(negedge clk);
    endtask

    task automatic idle(int c);
        repeat (c) tick();
    endtask

    task automatic pulse(int i, logic [7:0] d);
        smp[i] = d;
        vld[i] = 1'b1;
        tick();
        vld[i] = 1'b0;
    endtask

    task automatic frame_ok(string tag, int i, logic [15:0] f);
        check({tag, "_frame"}, 32'(rx_last[i]), 32'(f));
        check({tag, "_bits"}, 32'(rx_nbits[i]), 32'd16);
    endtask

    initial begin
        int v, d0, o0, b0c;
        for (int i = 0; i < 3; i++) begin
            smp[i] = 0; vld[i] = 0; prev[i] = 7'b1001000; rx[i] = 0; rx_last[i] = 0;
            rx_bits[i] = 0; rx_nbits[i] = 0; stray[i] = 0; done_cnt[i] = 0;
            ovr_cnt[i] = 0; busy_cnt[i] = 0; fd_n[i] = -1;
        end
        model_reset();
        @(negedge clk);
        idle(3);
        reset = 1'b0;
        idle(5);

        v = n;
        pulse(0, 8'hA5);
        idle(75);
        frame_ok("t1", 0, 16'h3A50);
        check("t1_done_at", 32'(fd_n[0] - v), 32'd68);
        check("t1_last", 32'(lst[0]), 32'hA5);

        d0 = done_cnt[0]; o0 = ovr_cnt[0];
        pulse(0, 8'h12);
        idle(10);
        pulse(0, 8'h34);
        idle(10);
        pulse(0, 8'h56);
        idle(130);
        check("t2_frames", 32'(done_cnt[0] - d0), 32'd2);
        check("t2_overrun", 32'(ovr_cnt[0] - o0), 32'd1);
        frame_ok("t2", 0, 16'h3560);

        d0 = done_cnt[1]; o0 = ovr_cnt[1];
        smp[1] = 8'hFF;
        idle(1000);
        smp[1] = 8'h00;
        idle(100);
        check("t3_frames", 32'(done_cnt[1] - d0), 32'd2);
        check("t3_overrun", 32'(ovr_cnt[1] - o0), 32'd0);
        frame_ok("t3", 1, 16'h3000);

        d0 = done_cnt[0];
        pulse(0, 8'h80);
        idle(19);
        reset = 1'b1;
        model_reset();
        tick();
        check("t4_idle_pins", 32'(obs[0][6:2]), 32'b10010);
        idle(2);
        reset = 1'b0;
        idle(3);
        check("t4_no_done", 32'(done_cnt[0] - d0), 32'd0);
        check("t4_last", 32'(lst[0]), 32'h00);
        pulse(0, 8'h3C);
        idle(75);
        frame_ok("t4", 0, 16'h33C0);

        b0c = busy_cnt[2];
        pulse(2, 8'hFF);
        idle(40);
        check("t5_busy", 32'(busy_cnt[2] - b0c), 32'd34);
        frame_ok("t5", 2, 16'h3FF0);

        d0 = done_cnt[0]; o0 = ovr_cnt[0];
        pulse(0, 8'h11);
        idle(67);
        v = n;
        pulse(0, 8'h77);
        check("t6_done_cycle", 32'(fd_n[0]), 32'(v));
        idle(80);
        check("t6_frames", 32'(done_cnt[0] - d0), 32'd2);
        check("t6_overrun", 32'(ovr_cnt[0] - o0), 32'd0);
        frame_ok("t6", 0, 16'h3770);
        check("t6_last", 32'(lst[0]), 32'h77);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                vld[i] = $urandom_range(0, 29) == 0;
                if (vld[i] || $urandom_range(0, 59) == 0) smp[i] = 8'($urandom);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        idle(200);
        for (int i = 0; i < 3; i++) check($sformatf("stray_sclk%0d", i), 32'(stray[i]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
